packet_word_packer: RTL and testbench
=====================================

PACKET_WORD_PACKER -- requirements
Module: packet_word_packer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, maximum accepted packet length in bytes (range 1..65535).
REQ-002 SHALL have port iClk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port iReset  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port iValid  input  1  iByte carries a valid byte this cycle.
REQ-005 SHALL have port iByte  input  8  stream byte.
REQ-006 SHALL have port iSop  input  1  first byte of packet; qualified by iValid.
REQ-007 SHALL have port iEop  input  1  last byte of packet; qualified by iValid.
REQ-008 SHALL have port oValid  output  1  output word valid; feeds the payload aligner's iValid.
REQ-009 SHALL have port oPacket  output  64  packed word; byte 0 of the word in bits [63:56].
REQ-010 SHALL have port oSop  output  1  word holds the packet's first byte.
REQ-011 SHALL have port oEop  output  1  word holds the packet's last byte.
REQ-012 SHALL have port oByte_enable  output  8  bit 7 = byte lane 0; valid lanes contiguous from bit 7.
REQ-013 SHALL have port oLength  output  16  total packet byte count; meaningful only when oValid and oEop are both high, otherwise 0.
REQ-014 SHALL have port oError  output  1  packet malformed or truncated; meaningful only when oValid and oEop are both high, otherwise 0.

Function
REQ-015 SHALL implement states IDLE, ACCUM and DROP.
REQ-016 IDLE: a valid byte with iSop loads lane 0, sets the length counter to 1 and moves to ACCUM; a valid byte without iSop is discarded and stays in IDLE.
REQ-017 ACCUM: each valid byte writes the next lane and increments the length counter; iValid low holds all state (gaps are allowed).
REQ-018 SHALL assert oValid for exactly one cycle, on the cycle after the byte that fills lane 7, with oByte_enable = 8'hFF.
REQ-019 On iEop, SHALL emit the partial word on the next cycle: oEop=1, oByte_enable with the top N bits set for N filled lanes, unused lanes 0, then return to IDLE.
REQ-020 SHALL assert oSop only on the first word of a packet; a 1-byte packet SHALL give oSop=oEop=1 and oByte_enable=8'h80.
REQ-021 iSop and iEop on the same byte SHALL be a 1-byte packet.
REQ-022 iSop in ACCUM SHALL close the current packet as a partial word with oEop=1 and oError=1, and the new byte SHALL start the next packet; no byte is lost.
REQ-023 If iSop arrives while an iEop flush is still being emitted, the flush SHALL be output unchanged and the new byte SHALL load lane 0.
REQ-024 Latency SHALL be exactly 1 cycle from the last byte of a word to oValid; outputs are registered; there is no backpressure.
REQ-025 The length counter SHALL saturate at 16'hFFFF.

Reset
REQ-026 While iReset=0, SHALL force state to IDLE and clear lane fill and length.
REQ-027 While iReset=0, SHALL drive oValid, oSop, oEop, oError = 0 and oPacket, oByte_enable, oLength = 0.
REQ-028 A partial packet in progress at reset SHALL be discarded without output.
REQ-029 SHALL resume normal operation on the first rising edge after deassertion.

Configuration
REQ-030 Macro PACKER_LEN_CHECK_EN SHALL gate the length check.
REQ-031 With PACKER_LEN_CHECK_EN defined, the byte that takes the length past MAX_LEN SHALL not be stored.
REQ-032 With PACKER_LEN_CHECK_EN defined, the packed bytes held so far SHALL be emitted with oEop=1, oError=1 and oLength=MAX_LEN.
REQ-033 With PACKER_LEN_CHECK_EN defined, the block SHALL enter DROP, discard bytes until iEop (exit to IDLE) or iSop (start a new packet).
REQ-034 Without PACKER_LEN_CHECK_EN, SHALL omit MAX_LEN logic and the DROP state; packets of any length pass.

Verification
REQ-035 Reset, then 26 bytes 0x00..0x19 back-to-back with iSop on byte 0 and iEop on byte 25 -> 4 words; word0 oSop=1, oPacket=64'h0001020304050607, BE=FF; word3 oEop=1, oPacket=64'h1819000000000000, BE=C0, oLength=26, oError=0.
REQ-036 1-byte packet 0xAB -> one word, oSop=oEop=1, oPacket=64'hAB00000000000000, BE=80, oLength=1.
REQ-037 8-byte packet with iValid low every other cycle -> one word, BE=FF, oSop=oEop=1, one cycle after byte 7.
REQ-038 3 bytes then iSop without iEop -> word with BE=E0, oEop=1, oError=1, oLength=3; the next packet then packs from lane 0.
REQ-039 PACKER_LEN_CHECK_EN defined, MAX_LEN=10, 20-byte packet -> words with BE=FF, then BE=C0 with oEop=1, oError=1, oLength=10; no further output until the next iSop.
REQ-040 Reset asserted mid-packet after 5 bytes -> all outputs 0 immediately; after release, a fresh 2-byte packet gives BE=C0, oLength=2.

Source files
------------

// File: rtl/packet_word_packer.sv
// Packs a byte stream into 64-bit words, byte 0 in bits [63:56], with SOP/EOP/length/error marking.
// Define PACKER_LEN_CHECK_EN to truncate packets longer than MAX_LEN and drop the remainder.
module packet_word_packer #(
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iValid,
    input  logic [7:0]  iByte,
    input  logic        iSop,
    input  logic        iEop,
    output logic        oValid,
    output logic [63:0] oPacket,
    output logic        oSop,
    output logic        oEop,
    output logic [7:0]  oByte_enable,
    output logic [15:0] oLength,
    output logic        oError
);

    if (MAX_LEN == 0 || MAX_LEN > 65535) begin : g_max_len_range
        $error("packet_word_packer: MAX_LEN must be in 1..65535");
    end

`ifdef PACKER_LEN_CHECK_EN
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCUM} state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  lane_q, lane_d;
    logic [15:0] len_q, len_d;
    logic        first_q, first_d;
    logic        pend_q, pend_d;

    logic        valid_q, valid_d;
    logic [63:0] pkt_q, pkt_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [7:0]  be_q, be_d;
    logic [15:0] olen_q, olen_d;
    logic        err_q, err_d;

    logic        start_v;
    logic [3:0]  lane_n;
    logic [15:0] len_n;
    logic [63:0] word_n;

    function automatic logic [7:0] lane_mask(input logic [3:0] n);
        return ~(8'hFF >> n);
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        lane_d  = lane_q;
        len_d   = len_q;
        first_d = first_q;
        pend_d  = 1'b0;
        valid_d = 1'b0;
        pkt_d   = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        be_d    = '0;
        olen_d  = '0;
        err_d   = 1'b0;
        start_v = 1'b0;
        lane_n  = lane_q + 4'd1;
        len_n   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        word_n  = data_q | ({iByte, 56'd0} >> {lane_q[2:0], 3'b000});

        // A 1-byte packet that collided with another output last cycle goes out now.
        if (pend_q) begin
            valid_d = 1'b1;
            pkt_d   = data_q;
            sop_d   = first_q;
            eop_d   = 1'b1;
            be_d    = lane_mask(lane_q);
            olen_d  = len_q;
            data_d  = '0;
            lane_d  = '0;
            len_d   = '0;
            first_d = 1'b0;
        end

        if (iValid) begin
            unique case (state_q)
                IDLE: start_v = iSop;
                ACCUM: begin
                    if (iSop) begin
                        valid_d = 1'b1;
                        pkt_d   = data_q;
                        sop_d   = first_q;
                        eop_d   = 1'b1;
                        be_d    = lane_mask(lane_q);
                        olen_d  = len_q;
                        err_d   = 1'b1;
                        start_v = 1'b1;
                    end
`ifdef PACKER_LEN_CHECK_EN
                    else if (len_q >= MAX_LEN_W) begin
                        valid_d = 1'b1;
                        pkt_d   = data_q;
                        sop_d   = first_q;
                        eop_d   = 1'b1;
                        be_d    = lane_mask(lane_q);
                        olen_d  = MAX_LEN_W;
                        err_d   = 1'b1;
                        data_d  = '0;
                        lane_d  = '0;
                        len_d   = '0;
                        first_d = 1'b0;
                        state_d = iEop ? IDLE : DROP;
                    end
`endif
                    else begin
                        data_d = word_n;
                        lane_d = lane_n;
                        len_d  = len_n;
                        if (lane_n == 4'd8 || iEop) begin
                            valid_d = 1'b1;
                            pkt_d   = word_n;
                            sop_d   = first_q;
                            eop_d   = iEop;
                            be_d    = lane_mask(lane_n);
                            olen_d  = iEop ? len_n : 16'd0;
                            data_d  = '0;
                            lane_d  = '0;
                            first_d = 1'b0;
                            if (iEop) begin
                                len_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
`ifdef PACKER_LEN_CHECK_EN
                DROP: begin
                    if (iSop)      start_v = 1'b1;
                    else if (iEop) state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        if (start_v) begin
            data_d  = {iByte, 56'd0};
            lane_d  = 4'd1;
            len_d   = 16'd1;
            first_d = 1'b1;
            state_d = ACCUM;
            if (iEop) begin
                state_d = IDLE;
                if (valid_d) begin
                    pend_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    pkt_d   = {iByte, 56'd0};
                    sop_d   = 1'b1;
                    eop_d   = 1'b1;
                    be_d    = 8'h80;
                    olen_d  = 16'd1;
                    data_d  = '0;
                    lane_d  = '0;
                    len_d   = '0;
                    first_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            data_q  <= '0;
            lane_q  <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            pkt_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            be_q    <= '0;
            olen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            len_q   <= len_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            be_q    <= be_d;
            olen_q  <= olen_d;
            err_q   <= err_d;
        end
    end

    assign oValid       = valid_q;
    assign oPacket      = pkt_q;
    assign oSop         = sop_q;
    assign oEop         = eop_q;
    assign oByte_enable = be_q;
    assign oLength      = olen_q;
    assign oError       = err_q;

endmodule

// File: tb/tb_packet_word_packer.sv
// Scoreboard bench for packet_word_packer: expected words are built from each packet's bytes
// as they are driven and compared, with their arrival cycle, when the DUT emits a word.
module tb_packet_word_packer;

`ifdef PACKER_LEN_CHECK_EN
    localparam int MAX_LEN   = 10;
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam int MAX_LEN   = 1518;
    localparam bit LEN_CHECK = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iReset = 1'b0;
    logic        iValid = 1'b0;
    logic [7:0]  iByte = 8'h00;
    logic        iSop = 1'b0;
    logic        iEop = 1'b0;
    logic        oValid;
    logic [63:0] oPacket;
    logic        oSop;
    logic        oEop;
    logic [7:0]  oByte_enable;
    logic [15:0] oLength;
    logic        oError;

    packet_word_packer #(.MAX_LEN(MAX_LEN)) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iValid       (iValid),
        .iByte        (iByte),
        .iSop         (iSop),
        .iEop         (iEop),
        .oValid       (oValid),
        .oPacket      (oPacket),
        .oSop         (oSop),
        .oEop         (oEop),
        .oByte_enable (oByte_enable),
        .oLength      (oLength),
        .oError       (oError)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] pkt;
        logic        sop;
        logic        eop;
        logic [7:0]  be;
        logic [15:0] len;
        logic        err;
        int          at;
    } exp_t;

    exp_t       sb[$];
    exp_t       held;
    bit         held_v = 1'b0;
    exp_t       mon_e;
    logic [7:0] pkt[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge iClk) begin
        if (iReset) begin
            if (oValid) begin
                check_eq("word_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check_eq("word_cycle", 64'(cyc), 64'(mon_e.at));
                    check_eq("oPacket", oPacket, mon_e.pkt);
                    check_eq("oSop", 64'(oSop), 64'(mon_e.sop));
                    check_eq("oEop", 64'(oEop), 64'(mon_e.eop));
                    check_eq("oByte_enable", 64'(oByte_enable), 64'(mon_e.be));
                    check_eq("oLength", 64'(oLength), 64'(mon_e.len));
                    check_eq("oError", 64'(oError), 64'(mon_e.err));
                end
            end else begin
                check_eq("idle_len_err", {47'd0, oLength, oError}, 64'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] b, input logic s, input logic e);
        @(negedge iClk);
        iValid = v;
        iByte  = b;
        iSop   = s;
        iEop   = e;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic exp_t make_word(input logic [7:0] bytes[$], input int start, input int cnt,
                                       input logic sop, input logic eop, input logic [15:0] len,
                                       input logic err, input int at);
        exp_t w;
        w.pkt = '0;
        w.be  = '0;
        for (int j = 0; j < cnt; j++) begin
            w.pkt[63-8*j -: 8] = bytes[start+j];
            w.be[7-j]          = 1'b1;
        end
        w.sop = sop;
        w.eop = eop;
        w.len = len;
        w.err = err;
        w.at  = at;
        return w;
    endfunction

    // mode 0: ends with iEop; 1: left open, closed with error by the next iSop; 2: abandoned
    task automatic send_packet(input logic [7:0] bytes[$], input bit gaps, input int mode);
        int n;
        int eff;
        int extra;
        bit trunc;
        bit last;
        n     = bytes.size();
        trunc = LEN_CHECK && (n > MAX_LEN);
        eff   = trunc ? MAX_LEN : n;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bytes[i], i == 0, (i == n - 1) && (mode == 0));
            extra = 0;
            if (i == 0 && held_v) begin
                held.at = cyc + 1;
                sb.push_back(held);
                held_v = 1'b0;
                extra  = 1;
            end
            last = (i == n - 1);
            if (!trunc || i < eff) begin
                if (i % 8 == 7 || last) begin
                    if (!last || mode == 0)
                        sb.push_back(make_word(bytes, i - i % 8, i % 8 + 1, i < 8, last,
                                               last ? 16'(n) : 16'd0, 1'b0, cyc + 1 + extra));
                    else if (mode == 1) begin
                        held   = make_word(bytes, i - i % 8, i % 8 + 1, i < 8, 1'b1, 16'(n), 1'b1, 0);
                        held_v = 1'b1;
                    end
                end
            end else if (i == eff) begin
                sb.push_back(make_word(bytes, eff - eff % 8, eff % 8, eff < 8, 1'b1,
                                       16'(MAX_LEN), 1'b1, cyc + 1));
            end
            if (gaps && !last) drive(1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic make_pkt(input int n, input int base);
        pkt = {};
        for (int i = 0; i < n; i++) pkt.push_back(8'(base + i));
    endtask

    initial begin
        repeat (3) @(negedge iClk);
        check_eq("rst_oValid", 64'(oValid), 64'd0);
        check_eq("rst_oPacket", oPacket, 64'd0);
        check_eq("rst_oSop", 64'(oSop), 64'd0);
        check_eq("rst_oEop", 64'(oEop), 64'd0);
        check_eq("rst_oBE", 64'(oByte_enable), 64'd0);
        check_eq("rst_oLength", 64'(oLength), 64'd0);
        check_eq("rst_oError", 64'(oError), 64'd0);
        @(negedge iClk);
        iReset = 1'b1;

        make_pkt(26, 0);
        send_packet(pkt, 1'b0, 0);
        idle(3);

        pkt = {8'hAB};
        send_packet(pkt, 1'b0, 0);
        idle(2);

        make_pkt(8, 8'h40);
        send_packet(pkt, 1'b1, 0);
        idle(2);

        make_pkt(3, 8'h60);
        send_packet(pkt, 1'b0, 1);
        make_pkt(5, 8'h70);
        send_packet(pkt, 1'b0, 0);
        idle(2);

        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b1, 8'h78, 1'b0, 1'b1);
        drive(1'b1, 8'h79, 1'b0, 1'b0);
        idle(2);

        make_pkt(11, 8'h80);
        send_packet(pkt, 1'b0, 0);
        make_pkt(9, 8'h90);
        send_packet(pkt, 1'b0, 0);
        pkt = {8'hC1};
        send_packet(pkt, 1'b0, 0);
        pkt = {8'hC2};
        send_packet(pkt, 1'b0, 0);
        make_pkt(2, 8'hC3);
        send_packet(pkt, 1'b0, 0);
        idle(2);

        make_pkt(4, 8'hD0);
        send_packet(pkt, 1'b0, 1);
        pkt = {8'hDD};
        send_packet(pkt, 1'b0, 0);
        idle(3);

        make_pkt(20, 8'hE0);
        send_packet(pkt, 1'b0, 0);
        idle(3);

`ifdef PACKER_LEN_CHECK_EN
        make_pkt(15, 8'h10);
        send_packet(pkt, 1'b0, 2);
        make_pkt(3, 8'h30);
        send_packet(pkt, 1'b0, 0);
        idle(2);
`endif

        for (int p = 0; p < 25; p++) begin
            pkt = {};
            for (int i = 0; i < $urandom_range(1, 30); i++) pkt.push_back(8'($urandom));
            send_packet(pkt, 1'($urandom_range(0, 1)), 0);
            idle($urandom_range(0, 2));
        end
        idle(3);

        make_pkt(13, 8'hA0);
        send_packet(pkt, 1'b0, 2);
        idle(1);
        @(negedge iClk);
        iReset = 1'b0;
        #1;
        check_eq("mid_rst_oValid", 64'(oValid), 64'd0);
        check_eq("mid_rst_oBE", 64'(oByte_enable), 64'd0);
        check_eq("mid_rst_oLength", 64'(oLength), 64'd0);
        idle(2);
        iReset = 1'b1;
        make_pkt(2, 8'hB0);
        send_packet(pkt, 1'b0, 0);
        idle(3);

        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        @(posedge iClk);
        #1;
        check_eq("async_pre_oValid", 64'(oValid), 64'd1);
        check_eq("async_pre_oPacket", oPacket, 64'h5A00000000000000);
        #1;
        iReset = 1'b0;
        iValid = 1'b0;
        iSop   = 1'b0;
        iEop   = 1'b0;
        #1;
        check_eq("async_oValid", 64'(oValid), 64'd0);
        check_eq("async_oPacket", oPacket, 64'd0);
        check_eq("async_oSop", 64'(oSop), 64'd0);
        check_eq("async_oEop", 64'(oEop), 64'd0);
        check_eq("async_oBE", 64'(oByte_enable), 64'd0);
        check_eq("async_oLength", 64'(oLength), 64'd0);
        check_eq("async_oError", 64'(oError), 64'd0);
        idle(2);
        iReset = 1'b1;
        make_pkt(2, 8'hF0);
        send_packet(pkt, 1'b0, 0);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge iClk);
        idle(2);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
